// File: rtl/fp_addsub_if.sv
// Operand-issue / result-writeback bundle for the pipelined FP add/sub unit.
// The slave side is the arithmetic unit; the master side issues operands and drains results.
interface fp_addsub_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  modport slave (
    input  in_valid, a, b, op, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flags
  );

  modport master (
    output in_valid, a, b, op, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Parametrised IEEE-754 add/subtract, 4 stages: classify/swap, align, add+LZC, normalise/round/pack.
// RNE rounding, denormals flushed to zero, one global advance enable drives all stages.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic        clk,
  input logic        rst,
  fp_addsub_if.slave io
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int STAGES = 4;
  localparam int MW     = MAN_W + 1;          // mantissa incl. hidden bit
  localparam int XW     = MAN_W + 4;          // plus guard, round, sticky
  localparam int EXTW   = MW + MAN_W + 3;     // alignment scratch width
  localparam int LZW    = $clog2(XW + 1);
  localparam int EW     = EXP_W + 2;          // working exponent, MSB = negative
  localparam int MRW    = MW + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
    logic             sx;
    logic             eff_sub;
  } side_t;

  typedef struct packed {
    side_t            sd;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] ey;
    logic [MW-1:0]    mx;
    logic [MW-1:0]    my;
  } s1_t;

  typedef struct packed {
    side_t            sd;
    logic [EXP_W-1:0] ex;
    logic [XW-1:0]    mx;
    logic [XW-1:0]    my;
  } s2_t;

  typedef struct packed {
    side_t            sd;
    logic [EXP_W-1:0] ex;
    logic [XW:0]      sum;
    logic [LZW-1:0]   lzc;
  } s3_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  s3_t             s3_q, s3_d;
  logic [W-1:0]    result_q, result_d;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]      flags_q, flags_d;
  logic            adv;

  assign adv         = !vld_pipe_q[STAGES] || io.out_ready;
  assign io.in_ready = adv;
  assign io.out_valid = vld_pipe_q[STAGES];
  assign io.result   = result_q;
  assign io.out_tag  = tag_q;
  assign io.flags    = flags_q;
  assign vld_pipe_d  = {vld_pipe_q[STAGES-1:1], io.in_valid};

  // ---------------- stage 1: unpack, classify, swap ----------------
  logic             sa, sb, sbe, eff_sub;
  logic [EXP_W-1:0] ea, eb, ea_n, eb_n;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma_n, mb_n;
  logic             za, zb, infa, infb, nana, nanb, snan, inf_inf, swap;

  assign {sa, ea, fa} = io.a;
  assign {sb, eb, fb} = io.b;
  assign sbe     = sb ^ io.op;
  assign eff_sub = sa ^ sbe;
  assign za      = (ea == '0);
  assign zb      = (eb == '0);
  assign infa    = (ea == EMAX) && (fa == '0);
  assign infb    = (eb == EMAX) && (fb == '0);
  assign nana    = (ea == EMAX) && (fa != '0);
  assign nanb    = (eb == EMAX) && (fb != '0);
  assign snan    = (nana && !fa[MAN_W-1]) || (nanb && !fb[MAN_W-1]);
  assign inf_inf = infa && infb && eff_sub;
  // Denormals collapse to a true zero before the magnitude compare.
  assign ea_n    = za ? '0 : ea;
  assign eb_n    = zb ? '0 : eb;
  assign ma_n    = za ? '0 : {1'b1, fa};
  assign mb_n    = zb ? '0 : {1'b1, fb};
  assign swap    = {eb_n, mb_n} > {ea_n, ma_n};

  always_comb begin
    s1_d            = '0;
    s1_d.sd.tag     = io.in_tag;
    s1_d.sd.sx      = swap ? sbe : sa;
    s1_d.sd.eff_sub = eff_sub;
    s1_d.ex         = swap ? eb_n : ea_n;
    s1_d.ey         = swap ? ea_n : eb_n;
    s1_d.mx         = swap ? mb_n : ma_n;
    s1_d.my         = swap ? ma_n : mb_n;
    if (nana || nanb || inf_inf) begin
      s1_d.sd.spec     = 1'b1;
      s1_d.sd.spec_res = QNAN;
      s1_d.sd.spec_flg = {snan || inf_inf, 3'b000};
    end else if (infa || infb) begin
      s1_d.sd.spec     = 1'b1;
      s1_d.sd.spec_res = {s1_d.sd.sx, EMAX, {MAN_W{1'b0}}};
    end
  end

  // ---------------- stage 2: align Y to X ----------------
  logic [EXP_W-1:0] diff;
  logic [EXTW-1:0]  sh;

  always_comb begin
    s2_d    = '0;
    s2_d.sd = s1_q.sd;
    s2_d.ex = s1_q.ex;
    s2_d.mx = {s1_q.mx, 3'b000};
    diff    = s1_q.ex - s1_q.ey;
    sh      = {s1_q.my, {(MAN_W+3){1'b0}}} >> diff;
    if (32'(diff) >= MAN_W + 3)
      s2_d.my = {{(XW-1){1'b0}}, |s1_q.my};
    else
      s2_d.my = {sh[EXTW-1 -: MAN_W+3], |sh[MAN_W:0]};
  end

  // ---------------- stage 3: add/subtract, leading-zero count ----------------
  always_comb begin
    s3_d     = '0;
    s3_d.sd  = s2_q.sd;
    s3_d.ex  = s2_q.ex;
    s3_d.sum = s2_q.sd.eff_sub ? ({1'b0, s2_q.mx} - {1'b0, s2_q.my})
                               : ({1'b0, s2_q.mx} + {1'b0, s2_q.my});
    s3_d.lzc = LZW'(XW);
    for (int i = 0; i < XW; i++)
      if (s3_d.sum[i]) s3_d.lzc = LZW'(XW - 1 - i);
  end

  // ---------------- stage 4: normalise, round, pack ----------------
  logic [XW-1:0] mn;
  logic [MRW-1:0] mr;
  logic [EW-1:0] e_n, e_f;
  logic          g, st, rup, under, over;

  always_comb begin
    if (s3_q.sum[XW]) begin
      mn  = {s3_q.sum[XW:2], |s3_q.sum[1:0]};
      e_n = EW'(s3_q.ex) + EW'(1);
    end else begin
      mn  = s3_q.sum[XW-1:0] << s3_q.lzc;
      e_n = EW'(s3_q.ex) - EW'(s3_q.lzc);
    end
    g     = mn[2];
    st    = |mn[1:0];
    rup   = g && (st || mn[3]);
    mr    = {1'b0, mn[XW-1:3]} + MRW'(rup);
    // A rounding carry leaves 10..0, so the field is just the shifted zeros.
    e_f   = mr[MW] ? e_n + EW'(1) : e_n;
    under = e_f[EW-1] || (e_f == '0);
    over  = !under && (e_f >= {2'b00, EMAX});

    result_d = {s3_q.sd.sx, e_f[EXP_W-1:0], mr[MW] ? mr[MAN_W:1] : mr[MAN_W-1:0]};
    flags_d  = {3'b000, g || st};
    if (s3_q.sd.spec) begin
      result_d = s3_q.sd.spec_res;
      flags_d  = s3_q.sd.spec_flg;
    end else if (s3_q.sum == '0) begin
      result_d = {s3_q.sd.sx && !s3_q.sd.eff_sub, {(W-1){1'b0}}};
      flags_d  = '0;
    end else if (over) begin
      result_d = {s3_q.sd.sx, EMAX, {MAN_W{1'b0}}};
      flags_d  = 4'b0101;
    end else if (under) begin
      result_d = {s3_q.sd.sx, {(W-1){1'b0}}};
      flags_d  = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      result_q   <= '0;
      tag_q      <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      result_q   <= result_d;
      tag_q      <= s3_q.sd.tag;
      flags_q    <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe with a queue scoreboard and a negedge monitor.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (.clk(clk), .rst(rst), .io(bus));

  typedef struct {
    logic [31:0] r;
    logic [3:0]  t;
    logic [3:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ef,
                      input bit track);
    int n = 0;
    exp_t e;
    bus.a = a; bus.b = b; bus.op = op; bus.in_tag = tag; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept: in_ready stuck low for tag %0d", tag);
    end else if (track) begin
      e.r = er; e.t = tag; e.f = ef;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every handshake, checks stall behaviour.
  bit          stall_prev = 0;
  logic [39:0] hold_v;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("stall_hold", {bus.result, bus.out_tag, bus.flags}, hold_v);
      if (!bus.out_ready) chk("in_ready_stall", bus.in_ready, !bus.out_valid);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious: result %h tag %0d with nothing expected", bus.result, bus.out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e.r);
          chk("out_tag", bus.out_tag, e.t);
          chk("flags", bus.flags, e.f);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      hold_v     = {bus.result, bus.out_tag, bus.flags};
    end
  end

  localparam int NV = 18;
  logic [31:0] va [NV] = '{32'h3FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
                           32'h40400000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'h7F800001,
                           32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h00800001, 32'h3FFFFFFF,
                           32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vb [NV] = '{32'h3FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h33800000, 32'h33800001,
                           32'h3F800000, 32'h80000000, 32'h80000000, 32'h3F800000, 32'h3F800000,
                           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000, 32'h33800000,
                           32'h33800000, 32'hBF800000, 32'hBF800000};
  logic        vop[NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] vr [NV] = '{32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h3F800001,
                           32'h40000000, 32'h80000000, 32'h00000000, 32'h7F800000, 32'h7FC00000,
                           32'h7FC00000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'h40000000,
                           32'h3F7FFFFF, 32'h00000000, 32'h40000000};
  logic [3:0]  vf [NV] = '{4'h0, 4'h8, 4'h5, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8,
                           4'h0, 4'h0, 4'h0, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0};

  logic [31:0] sb_b [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] sb_r [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  initial begin
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_out_tag", bus.out_tag, 4'h0);
    chk("rst_flags", bus.flags, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single op, unstalled latency
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 4'h0, 1'b1);
    chk("lat_cycle1", bus.out_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("lat_cycle3", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("lat_cycle4", bus.out_valid, 1'b1);
    drain("drain_latency");

    for (int i = 0; i < NV; i++)
      send(va[i], vb[i], vop[i], 4'(i), vr[i], vf[i], 1'b1);
    drain("drain_vectors");

    // 8 back-to-back beats, consumer stalls for cycles 6-9
    fork
      for (int i = 0; i < 8; i++)
        send(32'h3F800000, sb_b[i], 1'b0, 4'(8 + i), sb_r[i], 4'h0, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++)
      send(32'h3F800000, 32'h3F800000, 1'b0, 4'(i + 1), 32'h0, 4'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("post_rst_stale", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
